// File: rtl/usb_frame_scheduler_pkg.sv
// Shared types, widths and helpers for the USB full-speed frame scheduler.
package usb_frame_scheduler_pkg;

    localparam int FRAME_NUM_W = 11;
    localparam int FRAME_POS_W = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SOF   = 2'd1,
        ST_ARB   = 2'd2,
        ST_GRANT = 2'd3
    } sched_state_e;

    // Frame length in clocks.
    function automatic int frame_clks(input int mhz, input int us);
        return mhz * us;
    endfunction

    // (base + off) mod n, for base < n and off <= n.
    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/usb_frame_scheduler_rr_arbiter.sv
// Round-robin pick: lowest-index active request at or after the pointer, wrapping.
module usb_rr_arbiter
    import usb_frame_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest active request wins.
    always_comb begin
        pick_o  = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'(wrap_idx(int'(ptr_i), i, NUM_REQ));
            if (req_i[cand]) begin
                pick_o       = '0;
                pick_o[cand] = 1'b1;
                idx_o        = cand;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_frame_scheduler.sv
// Host-side FS frame scheduler: 1 ms frame timer, SOF requests, round-robin
// sharing of the remaining bus time with an end-of-frame guard window.
module usb_frame_scheduler
    import usb_frame_scheduler_pkg::*;
#(
    parameter int CLK_FREQ_MHZ   = 12,
    parameter int FRAME_US       = 1000,
    parameter int NUM_REQ        = 4,
    parameter int EOF_GUARD_CLKS = 600
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   enable,
    input  logic [NUM_REQ-1:0]     req,
    input  logic                   done,
    input  logic                   sof_ack,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   sof_req,
    output logic [FRAME_NUM_W-1:0] frame_num,
    output logic [FRAME_POS_W-1:0] frame_pos,
    output logic                   busy,
    output logic                   sof_late
);

    localparam int FRAME_CLKS = frame_clks(CLK_FREQ_MHZ, FRAME_US);
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [FRAME_POS_W-1:0] POS_LAST    = FRAME_POS_W'(FRAME_CLKS - 1);
    localparam logic [FRAME_POS_W-1:0] GUARD_START = FRAME_POS_W'(FRAME_CLKS - EOF_GUARD_CLKS);

    sched_state_e           state_q;
    logic [NUM_REQ-1:0]     grant_q;
    logic                   sof_req_q;
    logic [FRAME_NUM_W-1:0] frame_num_q;
    logic [FRAME_POS_W-1:0] frame_pos_q;
    logic                   sof_due_q;
    logic                   sof_late_q;
    logic [IDX_W-1:0]       ptr_q;

    logic [NUM_REQ-1:0] arb_pick;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic               wrap;
    logic               sof_pend;

    usb_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .pick_o  (arb_pick),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // A wrap on this clock counts as an SOF already due, so the SOF lands at frame_pos 0.
    assign wrap     = (state_q != ST_IDLE) && (frame_pos_q == POS_LAST);
    assign sof_pend = sof_due_q | wrap;

    // Frame timer plus scheduler FSM; every output is a register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            sof_req_q   <= 1'b0;
            frame_num_q <= '0;
            frame_pos_q <= '0;
            sof_due_q   <= 1'b0;
            sof_late_q  <= 1'b0;
            ptr_q       <= '0;
        end else begin
            if (state_q != ST_IDLE) begin
                if (wrap) begin
                    frame_pos_q <= '0;
                    frame_num_q <= frame_num_q + FRAME_NUM_W'(1);
                    sof_due_q   <= 1'b1;
                end else begin
                    frame_pos_q <= frame_pos_q + FRAME_POS_W'(1);
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q     <= ST_SOF;
                        sof_req_q   <= 1'b1;
                        frame_num_q <= '0;
                        sof_due_q   <= 1'b0;
                        sof_late_q  <= 1'b0;
                    end
                end
                ST_SOF: begin
                    if (sof_ack) begin
                        // A wrap on the ack clock leaves the next SOF already pending.
                        sof_due_q <= wrap;
                        if (!enable) begin
                            state_q     <= ST_IDLE;
                            sof_req_q   <= 1'b0;
                            frame_pos_q <= '0;
                        end else if (!wrap) begin
                            state_q   <= ST_ARB;
                            sof_req_q <= 1'b0;
                        end
                    end
                end
                ST_ARB: begin
                    if (sof_pend) begin
                        state_q   <= ST_SOF;
                        sof_req_q <= 1'b1;
                    end else if (frame_pos_q < GUARD_START) begin
                        if (!enable) begin
                            state_q     <= ST_IDLE;
                            frame_pos_q <= '0;
                        end else if (arb_valid) begin
                            state_q <= ST_GRANT;
                            grant_q <= arb_pick;
                            ptr_q   <= IDX_W'(wrap_idx(int'(arb_idx), 1, NUM_REQ));
                        end
                    end
                end
                ST_GRANT: begin
                    if (wrap) sof_late_q <= 1'b1;
                    if (done) begin
                        grant_q <= '0;
                        if (!enable) begin
                            state_q     <= ST_IDLE;
                            frame_pos_q <= '0;
                        end else if (sof_pend) begin
                            state_q   <= ST_SOF;
                            sof_req_q <= 1'b1;
                        end else begin
                            state_q <= ST_ARB;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign sof_req   = sof_req_q;
    assign frame_num = frame_num_q;
    assign frame_pos = frame_pos_q;
    assign busy      = sof_req_q | (|grant_q);
    assign sof_late  = sof_late_q;

endmodule
